glb_proc_bridge: RTL and testbench

Host-facing bridge that converts 32-bit single-beat host read/write requests into processor packets on the GLB `proc_ifc` driver port (`wr_*`/`rd_*`, `rd_data`/`rd_data_valid`). It sits directly upstream of the GLB processor-packet input. It packs host writes into `BANK_DATA_WIDTH` lanes with byte strobes. It tracks outstanding reads and buffers returned data so that no GLB read response is ever dropped, because the GLB has no read backpressure.

---
 rtl/glb_proc_bridge_if.sv | 45 ++++
 rtl/glb_proc_bridge.sv | 138 +++++++++++++
 tb/tb_glb_proc_bridge.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glb_proc_bridge_if.sv
// Host request/response channel plus GLB processor-packet port of glb_proc_bridge.
// Latency: none, signal bundle only.
// Backpressure: req_valid/req_ready and resp_valid/resp_ready handshakes; GLB read return has none.
// Ports: master = environment side (host + GLB); slave = bridge side.
interface glb_proc_bridge_if #(
    parameter int BANK_DATA_WIDTH = 64,
    parameter int GLB_ADDR_WIDTH  = 19
);
    // host request
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [GLB_ADDR_WIDTH-1:0]    req_addr;
    logic [31:0]                  req_wdata;
    logic [3:0]                   req_wstrb;
    // host response
    logic                         resp_valid;
    logic                         resp_ready;
    logic [31:0]                  resp_rdata;
    // GLB processor packet
    logic                         wr_en;
    logic [BANK_DATA_WIDTH/8-1:0] wr_strb;
    logic [GLB_ADDR_WIDTH-1:0]    wr_addr;
    logic [BANK_DATA_WIDTH-1:0]   wr_data;
    logic                         rd_en;
    logic [GLB_ADDR_WIDTH-1:0]    rd_addr;
    logic [BANK_DATA_WIDTH-1:0]   rd_data;
    logic                         rd_data_valid;
    // status
    logic                         err_unexpected_rd;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output rd_data, rd_data_valid,
        input  req_ready, resp_valid, resp_rdata,
        input  wr_en, wr_strb, wr_addr, wr_data, rd_en, rd_addr, err_unexpected_rd
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  rd_data, rd_data_valid,
        output req_ready, resp_valid, resp_rdata,
        output wr_en, wr_strb, wr_addr, wr_data, rd_en, rd_addr, err_unexpected_rd
    );
endinterface

// File: rtl/glb_proc_bridge.sv
// Generic FIFO storage: push/pop pointers only, occupancy is tracked by the owner.
// Latency: pushed entry visible at head the cycle after push.
// Backpressure: none internally; the owner must never push when full or pop when empty.
module glb_proc_bridge_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Host-to-GLB bridge: packs 32-bit host accesses into 64-bit GLB packets, buffers read returns.
// Latency: request accepted at edge N -> wr_en/rd_en in cycle N+1; rd_data_valid at M -> resp_valid at M+1.
// Backpressure: req_ready credit = RESP_DEPTH - (reads in flight + buffered responses); GLB return never stalled.
// Ports: clk, rst_n (async active-low), bus (glb_proc_bridge_if.slave: host req/resp + GLB packet port).
module glb_proc_bridge #(
    parameter int BANK_DATA_WIDTH = 64,
    parameter int GLB_ADDR_WIDTH  = 19,
    parameter int RESP_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    glb_proc_bridge_if.slave  bus
);
    localparam int             CW      = $clog2(RESP_DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(RESP_DEPTH);

    logic [CW-1:0] inflight;
    logic [CW-1:0] rcount;
    logic          lane;
    logic          accept;
    logic          wr_accept;
    logic          rd_issue;
    logic          rd_ret;
    logic          resp_pop;
    logic          tag_head;
    logic [31:0]   resp_push_dat;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^bus.req_addr[1:0];

    assign lane = bus.req_addr[2];

    // Writes also consume a credit check so there is a single acceptance rule.
    assign bus.req_ready = rst_n && (({1'b0, inflight} + {1'b0, rcount}) < DEPTH_C);
    assign accept        = bus.req_valid && bus.req_ready;
    assign wr_accept     = accept && bus.req_write;
    assign rd_issue      = accept && !bus.req_write;

    // A return with nothing outstanding is dropped and only flagged.
    assign rd_ret        = bus.rd_data_valid && (inflight != '0);
    assign bus.resp_valid = (rcount != '0);
    assign resp_pop      = bus.resp_valid && bus.resp_ready;

    assign resp_push_dat = tag_head ? bus.rd_data[BANK_DATA_WIDTH/2 +: 32] : bus.rd_data[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en             <= 1'b0;
            bus.rd_en             <= 1'b0;
            bus.wr_strb           <= '0;
            bus.wr_addr           <= '0;
            bus.wr_data           <= '0;
            bus.rd_addr           <= '0;
            bus.err_unexpected_rd <= 1'b0;
            inflight              <= '0;
            rcount                <= '0;
        end else begin
            bus.wr_en <= wr_accept;
            bus.rd_en <= rd_issue;
            // Data fields only move on their own accept so they hold between packets.
            if (wr_accept) begin
                bus.wr_addr <= {bus.req_addr[GLB_ADDR_WIDTH-1:3], 3'b000};
                bus.wr_data <= {2{bus.req_wdata}};
                bus.wr_strb <= lane ? {bus.req_wstrb, 4'h0} : {4'h0, bus.req_wstrb};
            end
            if (rd_issue) begin
                bus.rd_addr <= {bus.req_addr[GLB_ADDR_WIDTH-1:3], 3'b000};
            end
            if (bus.rd_data_valid && (inflight == '0)) begin
                bus.err_unexpected_rd <= 1'b1;
            end
            // Issue, return and pop may coincide; each contributes independently.
            inflight <= inflight + CW'(rd_issue) - CW'(rd_ret);
            rcount   <= rcount + CW'(rd_ret) - CW'(resp_pop);
        end
    end

    // Lane tag per outstanding read; returns are in order so the head matches the return.
    glb_proc_bridge_fifo #(.WIDTH(1), .DEPTH(RESP_DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_issue),
        .push_dat (lane),
        .pop      (rd_ret),
        .head_dat (tag_head)
    );

    glb_proc_bridge_fifo #(.WIDTH(32), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_ret),
        .push_dat (resp_push_dat),
        .pop      (resp_pop),
        .head_dat (bus.resp_rdata)
    );
endmodule

// File: tb/tb_glb_proc_bridge.sv
// Scoreboard bench for glb_proc_bridge: driver pushes expected packets/responses, monitor pops and compares.
// The GLB side is a responder with in-order, randomly delayed returns from an address-hashed memory.
module tb_glb_proc_bridge;
    localparam int BDW   = 64;
    localparam int GAW   = 19;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    glb_proc_bridge_if #(.BANK_DATA_WIDTH(BDW), .GLB_ADDR_WIDTH(GAW)) bus ();

    glb_proc_bridge #(.BANK_DATA_WIDTH(BDW), .GLB_ADDR_WIDTH(GAW), .RESP_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit             is_wr;
        logic [GAW-1:0] addr;
        logic [7:0]     strb;
        logic [63:0]    data;
        int             due;
    } pkt_t;

    typedef struct {
        logic [GAW-1:0] addr;
        int             due;
        int             epoch;
    } pend_t;

    pkt_t        pkt_q[$];
    logic [31:0] exp_q[$];
    pend_t       pend_q[$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int issued    = 0;
    int popped    = 0;
    int epoch     = 0;
    int lat_min   = 1;
    int lat_max   = 6;
    int spur_req  = 0;
    int spur_done = 0;
    bit exp_err   = 1'b0;
    bit mon_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // GLB memory contents: a fixed hash of the 8-byte-aligned address.
    function automatic logic [63:0] glb_data(input logic [GAW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        if (a == 19'h208) return 64'h11112222_33334444;
        return {w * 32'h9E3779B1 + 32'h01234567, (w ^ 32'h5A5A5A5A) * 32'h85EBCA6B};
    endfunction

    // One host cycle: check credit against the model, drive inputs, record expectations on accept.
    task automatic tick(input bit v, input bit w, input logic [GAW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit rr);
        logic [GAW-1:0] base;
        logic [7:0]     st;
        logic [63:0]    g;
        int             lane;
        @(posedge clk);
        #2;
        chk("req_ready", bus.req_ready, 64'((issued - popped) < DEPTH));
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_wstrb  = s;
        bus.resp_ready = rr;
        if (v && bus.req_ready) begin
            base = (a >> 3) << 3;
            lane = int'((a >> 2) & 1);
            if (w) begin
                st = 8'(s) << (4 * lane);
                pkt_q.push_back('{is_wr: 1'b1, addr: base, strb: st, data: {d, d}, due: cyc + 1});
            end else begin
                pkt_q.push_back('{is_wr: 1'b0, addr: base, strb: 8'h0, data: 64'h0, due: cyc + 1});
                g = glb_data(base);
                exp_q.push_back(lane != 0 ? g[63:32] : g[31:0]);
                issued++;
            end
        end
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, '0, rr);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #3;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        #1;
        chk("rst_wr_en",   bus.wr_en, 0);
        chk("rst_rd_en",   bus.rd_en, 0);
        chk("rst_wr_strb", bus.wr_strb, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_err", bus.err_unexpected_rd, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        pkt_q.delete();
        exp_q.delete();
        issued = popped;
        epoch++;
        repeat (hold) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", bus.req_ready, 1);
    endtask

    // GLB responder: captures rd_en, returns in order after a random delay.
    initial begin
        bit    set_next;
        pend_t p;
        set_next          = 1'b0;
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.rd_data_valid = 1'b0;
            if (!rst_n) begin
                exp_err  = 1'b0;
                set_next = 1'b0;
            end else if (set_next) begin
                exp_err  = 1'b1;
                set_next = 1'b0;
            end
            if (rst_n && mon_en) begin
                if (bus.rd_en) begin
                    pend_q.push_back('{addr: bus.rd_addr,
                                       due: cyc + int'($urandom_range(lat_max, lat_min)),
                                       epoch: epoch});
                end
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    p = pend_q.pop_front();
                    bus.rd_data_valid = 1'b1;
                    bus.rd_data       = glb_data(p.addr);
                    // Returns for reads issued before a reset have no owner any more.
                    if (p.epoch != epoch) set_next = 1'b1;
                end else if (spur_req != spur_done && pend_q.size() == 0) begin
                    spur_done++;
                    bus.rd_data_valid = 1'b1;
                    bus.rd_data       = {$urandom, $urandom};
                    set_next          = 1'b1;
                end
            end
        end
    end

    // Monitor: packets, responses, error flag and response-FIFO bound.
    initial begin
        pkt_t p;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) continue;
            chk("err_unexpected_rd", bus.err_unexpected_rd, exp_err);
            checks++;
            assert (dut.rcount <= 3'(DEPTH)) else begin
                failures++;
                $display("FAIL resp_fifo_overflow: rcount %0d above %0d", dut.rcount, DEPTH);
            end
            if (bus.wr_en || bus.rd_en) begin
                if (pkt_q.size() == 0) begin
                    flag("pkt_unexpected");
                end else begin
                    p = pkt_q.pop_front();
                    chk("pkt_cycle", 64'(cyc), 64'(p.due));
                    chk("pkt_kind", {bus.wr_en, bus.rd_en}, {p.is_wr, !p.is_wr});
                    if (p.is_wr) begin
                        chk("wr_addr", bus.wr_addr, p.addr);
                        chk("wr_strb", bus.wr_strb, p.strb);
                        chk("wr_data", bus.wr_data, p.data);
                    end else begin
                        chk("rd_addr", bus.rd_addr, p.addr);
                    end
                end
            end else if (pkt_q.size() > 0 && pkt_q[0].due <= cyc) begin
                flag("pkt_missing");
                void'(pkt_q.pop_front());
            end
            if (bus.resp_valid && bus.resp_ready) begin
                popped++;
                if (exp_q.size() == 0) flag("resp_unexpected");
                else chk("resp_rdata", bus.resp_rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        bit found;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.resp_ready = 1'b0;

        do_reset(2);
        mon_en = 1'b1;

        // Write lane packing
        tick(1'b1, 1'b1, 19'h104, 32'hDEADBEEF, 4'hF, 1'b0);
        tick(1'b1, 1'b1, 19'h100, 32'h0BADF00D, 4'h3, 1'b0);
        chk("wr104_en",   bus.wr_en, 1);
        chk("wr104_addr", bus.wr_addr, 19'h100);
        chk("wr104_strb", bus.wr_strb, 8'hF0);
        chk("wr104_data", bus.wr_data, 64'hDEADBEEF_DEADBEEF);
        idle(1, 1'b0);
        chk("wr100_strb", bus.wr_strb, 8'h03);
        chk("wr100_data", bus.wr_data, 64'h0BADF00D_0BADF00D);
        idle(1, 1'b0);
        chk("wr_en_one_cycle", bus.wr_en, 0);
        chk("wr_strb_hold", bus.wr_strb, 8'h03);
        tick(1'b1, 1'b1, 19'h7FFF4, 32'h12345678, 4'h0, 1'b0);
        idle(2, 1'b0);

        // Unexpected return while idle, then reset clears the flag
        spur_req++;
        idle(4, 1'b0);
        chk("err_set_idle", bus.err_unexpected_rd, 1);
        do_reset(2);

        // Read lane select, fixed latency 3
        lat_min = 3;
        lat_max = 3;
        tick(1'b1, 1'b0, 19'h20C, '0, '0, 1'b0);
        idle(1, 1'b0);
        chk("rd20c_en", bus.rd_en, 1);
        chk("rd20c_addr", bus.rd_addr, 19'h208);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            idle(1, 1'b0);
            found = bus.rd_data_valid;
        end
        if (!found) flag("rd20c_return_timeout");
        idle(1, 1'b0);
        chk("rd20c_resp_valid", bus.resp_valid, 1);
        chk("rd20c_resp_rdata", bus.resp_rdata, 32'h11112222);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Credit stall: four reads fill the credits, fifth waits for a pop
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 19'(32'h400 + 4 * i), '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 19'h414, '0, '0, 1'b0);
        chk("stall_ready", bus.req_ready, 0);
        chk("stall_resp_valid", bus.resp_valid, 1);
        tick(1'b1, 1'b0, 19'h414, '0, '0, 1'b1);
        tick(1'b1, 1'b0, 19'h414, '0, '0, 1'b0);
        idle(20, 1'b1);

        // Back-to-back reads with unit latency: issue, return and pop coincide
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 200; i++)
            tick(($urandom % 4) != 0, ($urandom % 5) == 0, 19'($urandom), $urandom, 4'($urandom), 1'b1);
        idle(10, 1'b1);

        // Random traffic
        lat_min = 1;
        lat_max = 6;
        for (int i = 0; i < 1500; i++)
            tick(($urandom % 4) != 0, ($urandom % 2) == 0, 19'($urandom), $urandom, 4'($urandom),
                 ($urandom % 3) != 0);
        idle(30, 1'b1);
        chk("mid_drain_resp", 64'(exp_q.size()), 0);

        // Reset mid-stream with reads in flight; their late returns must be flagged
        lat_min = 6;
        lat_max = 6;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 19'(32'h800 + 8 * i), '0, '0, 1'b0);
        do_reset(2);
        idle(15, 1'b1);
        chk("err_late_return", bus.err_unexpected_rd, 1);
        chk("late_resp_valid", bus.resp_valid, 0);

        idle(5, 1'b1);
        chk("final_resp_q", 64'(exp_q.size()), 0);
        chk("final_pkt_q", 64'(pkt_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
